// File: rtl/fp32_mant_pkg.sv
// Shared field widths, FSM encoding and small helpers for the FP32 mantissa
// datapath blocks (sequential multiplier and the planned radix-16 divider).
package fp32_mant_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam int OPND_W = EXP_W + FRAC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } mant_state_e;

  function automatic int niter(input int digit_w);
    return MANT_W / digit_w;
  endfunction

  // A zero exponent field means a denormal or zero, so the hidden bit is clear.
  function automatic logic [MANT_W-1:0] hidden_mant(input logic [OPND_W-1:0] opnd,
                                                    input logic [FRAC_W-1:0] frac_mask);
    return {|opnd[OPND_W-1:FRAC_W], opnd[FRAC_W-1:0] & frac_mask};
  endfunction

  // Takes product[47:23]; picks [46:24] when bit 47 is set, else [45:23].
  function automatic logic [FRAC_W-1:0] norm_field(input logic [PROD_W-FRAC_W-1:0] prod_hi);
    logic [FRAC_W-1:0] field_v;
    if (prod_hi[PROD_W-FRAC_W-1]) begin
      field_v = prod_hi[PROD_W-FRAC_W-2:1];
    end else begin
      field_v = prod_hi[FRAC_W-1:0];
    end
    return field_v;
  endfunction

endpackage

// File: rtl/mult_mant_seq_if.sv
// Operand/result handshake bundle between the FP multiplier control path
// and the sequential mantissa multiplier.
interface mult_mant_seq_if;
  import fp32_mant_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] a_operand;
  logic [OPND_W-1:0] b_operand;
  logic              out_valid;
  logic              out_ready;
  logic              normalised;
  logic [FRAC_W-1:0] product_mantissa;
  logic              busy;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, normalised, product_mantissa, busy
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, normalised, product_mantissa, busy
  );
endinterface

// File: rtl/mult_mant_seq_mac.sv
// One shift-add step: acc_out = acc_in + (ma * digit) << (shift_idx * DIGIT_W).
// Purely combinational so the divider can reuse it with its own sequencing.
module mant_digit_mac
  import fp32_mant_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 3
) (
  input  logic [MANT_W-1:0]  ma,
  input  logic [DIGIT_W-1:0] digit,
  input  logic [CNT_W-1:0]   shift_idx,
  input  logic [PROD_W-1:0]  acc_in,
  output logic [PROD_W-1:0]  acc_out
);

  logic [MANT_W+DIGIT_W-1:0] partial_s;

  assign partial_s = (MANT_W+DIGIT_W)'(ma) * (MANT_W+DIGIT_W)'(digit);
  assign acc_out   = acc_in + (PROD_W'(partial_s) << (int'(shift_idx) * DIGIT_W));

endmodule

// File: rtl/mult_mant_seq.sv
// Sequential FP32 mantissa multiplier: radix-2^DIGIT_W shift-add iterations
// followed by a one-cycle normalise stage, behind a valid/ready handshake.
module mult_mant_seq
  import fp32_mant_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int TRUNC   = 0
) (
  input  logic           clk,
  input  logic           rst,
  mult_mant_seq_if.slave bus
);

  localparam int NITER = niter(DIGIT_W);
  localparam int CNT_W = $clog2(NITER + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NITER - 1);
  localparam logic [FRAC_W-1:0] FRAC_MASK = ~((FRAC_W'(1) << TRUNC) - FRAC_W'(1));

  mant_state_e       state_r;
  mant_state_e       state_s;
  logic [MANT_W-1:0] ma_r;
  logic [MANT_W-1:0] mb_r;
  logic [PROD_W-1:0] acc_r;
  logic [PROD_W-1:0] acc_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              normalised_r;
  logic [FRAC_W-1:0] mant_r;
  logic              accept_s;

  assign accept_s = bus.in_valid && in_ready_r;

  mant_digit_mac #(
    .DIGIT_W (DIGIT_W),
    .CNT_W   (CNT_W)
  ) u_mac (
    .ma        (ma_r),
    .digit     (mb_r[DIGIT_W-1:0]),
    .shift_idx (cnt_r),
    .acc_in    (acc_r),
    .acc_out   (acc_s)
  );

  // Next-state logic for the IDLE/ITER/NORM/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ITER;
        else          state_s = IDLE;
      end
      ITER: begin
        if (cnt_r == LAST_CNT) state_s = NORM;
        else                   state_s = ITER;
      end
      NORM: state_s = DONE;
      DONE: begin
        if (out_valid_r && bus.out_ready) state_s = IDLE;
        else                              state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs; out_valid lags DONE entry by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ma_r         <= '0;
      mb_r         <= '0;
      acc_r        <= '0;
      cnt_r        <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      normalised_r <= 1'b0;
      mant_r       <= '0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_r == DONE) && (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ma_r  <= hidden_mant(bus.a_operand, FRAC_MASK);
            mb_r  <= hidden_mant(bus.b_operand, FRAC_MASK);
            acc_r <= '0;
            cnt_r <= '0;
          end
        end
        ITER: begin
          acc_r <= acc_s;
          mb_r  <= mb_r >> DIGIT_W;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        NORM: begin
          normalised_r <= acc_r[PROD_W-1];
          mant_r       <= norm_field(acc_r[PROD_W-1:FRAC_W]);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready         = in_ready_r;
  assign bus.out_valid        = out_valid_r;
  assign bus.busy             = busy_r;
  assign bus.normalised       = normalised_r;
  assign bus.product_mantissa = mant_r;

endmodule

// File: tb/tb_mult_mant_seq.sv
// Scoreboard bench for mult_mant_seq: directed and random operand pairs checked
// against an arithmetic reference, plus backpressure, reset-abort and TRUNC=8 cases.
module tb_mult_mant_seq;
  import fp32_mant_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rdy_rand;
  bit   rdy_force;

  typedef struct {
    logic        norm;
    logic [22:0] mant;
    int          acc_cyc;
  } sb_item_t;

  sb_item_t sb_q[$];

  mult_mant_seq_if bus_if ();
  mult_mant_seq_if bus8_if ();

  mult_mant_seq #(.DIGIT_W(4), .TRUNC(0)) u_dut (.clk(clk), .rst(rst), .bus(bus_if));
  mult_mant_seq #(.DIGIT_W(4), .TRUNC(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8_if));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: exact integer product of the hidden-bit mantissas, then field select.
  function automatic logic [23:0] ref_result(input logic [30:0] a, input logic [30:0] b, input int trunc);
    longint unsigned fa, fb, ma, mb, p, f;
    logic norm;
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    fa = (fa >> trunc) << trunc;
    fb = (fb >> trunc) << trunc;
    ma = fa + ((a[30:23] != 8'd0) ? (64'd1 << 23) : 64'd0);
    mb = fb + ((b[30:23] != 8'd0) ? (64'd1 << 23) : 64'd0);
    p  = ma * mb;
    norm = (p >= (64'd1 << 47));
    f = norm ? (p >> 24) : (p >> 23);
    f = f % (64'd1 << 23);
    return {norm, 23'(f)};
  endfunction

  function automatic logic [30:0] rand_opnd();
    logic [7:0] e;
    e = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    return {e, 23'($urandom)};
  endfunction

  // out_ready changes shortly after posedge so it is stable across the next sample and edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_rand) bus_if.out_ready = ($urandom_range(0, 2) != 0);
      else          bus_if.out_ready = rdy_force;
    end
  end

  // Monitor: latency on each out_valid rise, handshake sanity, pop-and-compare on transfer.
  initial begin
    logic     prev_ov;
    sb_item_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (bus_if.out_valid && !prev_ov) begin
          if (sb_q.size() == 0) check("unexpected_out_valid", 64'(bus_if.out_valid), 64'd0);
          else                  check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'd8);
        end
        if (bus_if.out_valid) begin
          check("in_ready_in_done", 64'(bus_if.in_ready), 64'd0);
          check("busy_in_done", 64'(bus_if.busy), 64'd1);
        end
        if (bus_if.out_valid && bus_if.out_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("normalised", 64'(bus_if.normalised), 64'(e.norm));
          check("product_mantissa", 64'(bus_if.product_mantissa), 64'(e.mant));
        end
        prev_ov = bus_if.out_valid;
      end
    end
  end

  task automatic issue(input logic [30:0] a, input logic [30:0] b, output int acc_cyc, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus_if.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 64'(bus_if.in_ready), 64'd1);
    ok = bus_if.in_ready;
    acc_cyc = cyc + 1;
    if (ok) begin
      bus_if.in_valid  = 1'b1;
      bus_if.a_operand = a;
      bus_if.b_operand = b;
      @(negedge clk);
      bus_if.in_valid  = 1'b0;
      bus_if.a_operand = 31'($urandom);
      bus_if.b_operand = 31'($urandom);
    end
  endtask

  task automatic send_exp(input logic [30:0] a, input logic [30:0] b, input logic norm, input logic [22:0] mant);
    int acc_cyc;
    bit ok;
    issue(a, b, acc_cyc, ok);
    if (ok) sb_q.push_back('{norm: norm, mant: mant, acc_cyc: acc_cyc});
  endtask

  task automatic send_rand();
    logic [30:0] a, b;
    logic [23:0] r;
    a = rand_opnd();
    b = rand_opnd();
    r = ref_result(a, b, 0);
    send_exp(a, b, r[23], r[22:0]);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic run8(input logic [30:0] a, input logic [30:0] b, input logic norm, input logic [22:0] mant);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus8_if.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("t8_in_ready", 64'(bus8_if.in_ready), 64'd1);
    bus8_if.in_valid  = 1'b1;
    bus8_if.a_operand = a;
    bus8_if.b_operand = b;
    @(negedge clk);
    bus8_if.in_valid = 1'b0;
    w = 0;
    while (!bus8_if.out_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("t8_out_valid", 64'(bus8_if.out_valid), 64'd1);
    check("t8_normalised", 64'(bus8_if.normalised), 64'(norm));
    check("t8_mantissa", 64'(bus8_if.product_mantissa), 64'(mant));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_cyc;
    bit          ok;
    bit          ov_seen;
    logic [23:0] r;
    logic [30:0] a, b;

    rst = 1'b1;
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.a_operand = '0;
    bus_if.b_operand = '0;
    bus8_if.in_valid = 1'b0;
    bus8_if.a_operand = '0;
    bus8_if.b_operand = '0;
    bus8_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_normalised", 64'(bus_if.normalised), 64'd0);
    check("rst_mantissa", 64'(bus_if.product_mantissa), 64'd0);
    rst = 1'b0;

    // Directed values
    send_exp(31'h3F800000, 31'h3F800000, 1'b0, 23'h000000);
    send_exp(31'h3FC00000, 31'h3FC00000, 1'b1, 23'h100000);
    send_exp(31'h3FFFFFFF, 31'h3FFFFFFF, 1'b1, 23'h7FFFFE);
    send_exp(31'h00000000, 31'h00000000, 1'b0, 23'h000000);
    send_exp(31'h00400000, 31'h3F800000, 1'b0, 23'h400000);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) send_rand();
    drain();

    // Backpressure: hold out_ready low, jiggle inputs, then release
    rdy_rand = 1'b0;
    rdy_force = 1'b0;
    repeat (2) @(negedge clk);
    send_exp(31'h3FC00000, 31'h3FC00000, 1'b1, 23'h100000);
    begin
      int w;
      w = 0;
      while (!bus_if.out_valid && w < 30) begin
        @(negedge clk);
        w++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.in_valid  = ~bus_if.in_valid;
      bus_if.a_operand = 31'($urandom);
      bus_if.b_operand = 31'($urandom);
      #1;
      check("hold_out_valid", 64'(bus_if.out_valid), 64'd1);
      check("hold_normalised", 64'(bus_if.normalised), 64'd1);
      check("hold_mantissa", 64'(bus_if.product_mantissa), 64'h100000);
      check("hold_in_ready", 64'(bus_if.in_ready), 64'd0);
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("release_in_ready", 64'(bus_if.in_ready), 64'd1);
    check("release_out_valid", 64'(bus_if.out_valid), 64'd0);
    send_exp(31'h3F800000, 31'h3FFFFFFF, 1'b0, 23'h7FFFFF);
    rdy_rand = 1'b1;
    drain();

    // Reset abort during ITER with cnt=3, after a nonzero result has been held
    send_exp(31'h00400000, 31'h3F800000, 1'b0, 23'h400000);
    drain();
    issue(31'h3FC00000, 31'h3FFFFFFF, acc_cyc, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus_if.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_normalised", 64'(bus_if.normalised), 64'd0);
    check("abort_mantissa", 64'(bus_if.product_mantissa), 64'd0);
    ov_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      ov_seen = ov_seen | bus_if.out_valid;
    end
    check("abort_no_result", 64'(ov_seen), 64'd0);
    send_rand();
    send_rand();
    drain();

    // Approximate variant with the low 8 fraction bits dropped
    run8(31'h3F8000FF, 31'h3F8000FF, 1'b0, 23'h000000);
    for (int i = 0; i < 20; i++) begin
      a = rand_opnd();
      b = rand_opnd();
      r = ref_result(a, b, 8);
      run8(a, b, r[23], r[22:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
